// File: rtl/sram_mem_responder_pkg.sv
// Shared definitions for the MEM-stage SRAM responder.
//  state_e      : access sequencer states (IDLE -> LOW -> HIGH -> DONE)
//  DEF_*        : default parameter values for the responder
//  CNT_W        : width of the phase counter (holds up to 15 wait cycles)
package sram_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 4;
  localparam int unsigned DEF_SRAM_AW     = 18;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/sram_mem_responder_phase_timer.sv
// Wait-state counter for one half-word SRAM phase.
//  clk           : clock, rising edge
//  rst_n         : asynchronous active-low reset
//  run_i         : 1 while a LOW or HIGH phase is in progress; 0 clears the count
//  last_o        : count is at WAIT_CYCLES-1 (final cycle of the phase)
//  strobe_next_o : the next cycle of this phase is still inside the write strobe
//                  window (count after increment below WAIT_CYCLES-1)
// WAIT_CYCLES must lie in 2..15.
module sram_mem_responder_phase_timer
  import sram_mem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic last_o,
  output logic strobe_next_o
);

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_END = CNT_W'(WAIT_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last_o        = (cnt_q == LAST_CNT);
  assign strobe_next_o = (cnt_q < STROBE_END);

  // The counter wraps to zero at the end of each phase so HIGH starts at 0
  // straight after LOW without an extra clear cycle.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!run_i || last_o) cnt_d = '0;
  end

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // flop samples the pre-edge values of its inputs regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sram_mem_responder.sv
// MEM-stage responder that performs 32-bit loads/stores on an external 16-bit
// asynchronous SRAM as two half-word phases (LOW then HIGH) with wait states.
//  clk, rst            : clock; asynchronous active-low reset
//  wr_en, rd_en        : store / load request from the MEM stage (store wins)
//  address, write_data : byte address and store data; latched at acceptance
//  read_data           : registered load result, valid from DONE onwards
//  ready               : 0 stalls the pipeline while an access is pending
//  sram_addr           : half-word address {word, half}
//  sram_dq_o/_oe       : write data and bus drive enable (tristate built above)
//  sram_dq_i           : read data from the SRAM
//  sram_we_n           : active-low write strobe; released on the last cycle
//                        of each phase so address/data are held past the edge
module sram_mem_responder
  import sram_mem_responder_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_we_n
);

  localparam logic [31:0] BASE = 32'(BASE_ADDR);

  state_e             state_q;
  logic               store_q;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;

  logic               req;
  logic               phase_last;
  logic               strobe_next;
  logic [31:0]        off;
  logic [SRAM_AW-2:0] word_d;
  logic               unused_off_bits;

  assign req = wr_en | rd_en;

  // Offset wraps modulo 2^32; byte lane bits and bits above the SRAM are dropped.
  assign off             = address - BASE;
  assign word_d          = off[SRAM_AW:2];
  assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};

  // Combinational so the pipeline freezes in the same cycle the request appears.
  assign ready = ~req | (state_q == ST_DONE);

  sram_mem_responder_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst),
    .run_i         ((state_q == ST_LOW) || (state_q == ST_HIGH)),
    .last_o        (phase_last),
    .strobe_next_o (strobe_next)
  );

  // SRAM pins are registered and set up on the edge that enters each phase, so
  // they are stable for the full first cycle of LOW/HIGH.
  // NOTE: every register here, including the latched request and read_data,
  // has a reset value so an access interrupted by rst leaves no stale state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      store_q    <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      read_data  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q    <= ST_LOW;
            store_q    <= wr_en;
            word_q     <= word_d;
            wdata_q    <= write_data;
            sram_addr  <= {word_d, 1'b0};
            sram_dq_o  <= write_data[15:0];
            sram_dq_oe <= wr_en;
            sram_we_n  <= ~wr_en;
          end
        end
        ST_LOW: begin
          if (phase_last) begin
            if (!store_q) read_data[15:0] <= sram_dq_i;
            state_q   <= ST_HIGH;
            sram_addr <= {word_q, 1'b1};
            sram_dq_o <= wdata_q[31:16];
            sram_we_n <= ~store_q;
          end else begin
            sram_we_n <= ~(store_q & strobe_next);
          end
        end
        ST_HIGH: begin
          if (phase_last) begin
            if (!store_q) read_data[31:16] <= sram_dq_i;
            state_q    <= ST_DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            sram_we_n <= ~(store_q & strobe_next);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed bench: two responders (WAIT_CYCLES=4 and 2) each attached to a
// behavioural 256Kx16 asynchronous SRAM with a tristate DQ bus.
module tb_sram_mem_responder;

  logic        clk;
  logic        rst;
  logic        wr_en      [2];
  logic        rd_en      [2];
  logic [31:0] address    [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data  [2];
  logic        ready      [2];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned WC = (g == 0) ? 4 : 2;

    wire  [15:0] dq;
    logic [15:0] dq_o;
    logic [15:0] dq_i;
    logic        dq_oe;
    logic        we_n;
    logic        we_n_prev;
    logic [17:0] addr;
    logic [15:0] mem [0:262143];

    sram_mem_responder #(
      .BASE_ADDR   (1024),
      .WAIT_CYCLES (WC),
      .SRAM_AW     (18)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en[g]),
      .rd_en      (rd_en[g]),
      .address    (address[g]),
      .write_data (write_data[g]),
      .read_data  (read_data[g]),
      .ready      (ready[g]),
      .sram_addr  (addr),
      .sram_dq_o  (dq_o),
      .sram_dq_oe (dq_oe),
      .sram_dq_i  (dq_i),
      .sram_we_n  (we_n)
    );

    // Bus: responder drives when dq_oe, otherwise the SRAM drives read data.
    assign dq   = dq_oe ? dq_o : 16'hzzzz;
    assign dq   = dq_oe ? 16'hzzzz : mem[addr];
    assign dq_i = dq;

    // Write completes on the rising edge of WE while the bus is still driven;
    // an abandoned write (bus released together with WE) stores nothing.
    always @(negedge clk) begin
      if (we_n_prev === 1'b0 && we_n === 1'b1 && dq_oe === 1'b1) mem[addr] <= dq;
      we_n_prev <= we_n;
    end
  end

  function automatic logic [15:0] peek(input int d, input int a);
    return (d == 0) ? g_dut[0].mem[a] : g_dut[1].mem[a];
  endfunction

  function automatic logic we_n_of(input int d);
    return (d == 0) ? g_dut[0].we_n : g_dut[1].we_n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request at a falling edge and runs until ready returns high
  // (the DONE cycle). Reports stall cycles, WE-low cycles and read_data there.
  task automatic access(input int d, input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] wd, input logic scr,
                        output int stall, output int we_low, output logic [31:0] rdata);
    stall  = 0;
    we_low = 0;
    @(negedge clk);
    wr_en[d]      = wr;
    rd_en[d]      = rd;
    address[d]    = a;
    write_data[d] = wd;
    #1;
    while (ready[d] !== 1'b1 && stall < 100) begin
      if (scr && stall == 1) begin
        address[d]    = 32'hFFFF_0000;
        write_data[d] = 32'h0BAD_0BAD;
      end
      if (we_n_of(d) === 1'b0) we_low++;
      stall++;
      @(negedge clk);
      #1;
    end
    rdata = read_data[d];
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    wr_en[d] = 1'b0;
    rd_en[d] = 1'b0;
  endtask

  initial begin
    int          stall;
    int          we_low;
    logic [31:0] rdata;

    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_en[i]      = 1'b0;
      rd_en[i]      = 1'b0;
      address[i]    = '0;
      write_data[i] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    check("rst_read_data", read_data[0], 32'h0);
    check("rst_we_n", 32'(g_dut[0].we_n), 32'd1);
    check("rst_oe", 32'(g_dut[0].dq_oe), 32'd0);
    check("rst_addr", 32'(g_dut[0].addr), 32'd0);
    check("rst_ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // 1: idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("idle_ready", 32'(ready[0]), 32'd1);
      check("idle_we_n", 32'(g_dut[0].we_n), 32'd1);
      check("idle_oe", 32'(g_dut[0].dq_oe), 32'd0);
    end

    // 2: store 0xDEADBEEF @1024
    access(0, 1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b0, stall, we_low, rdata);
    check("st1_stall", 32'(stall), 32'd9);
    check("st1_we_low", 32'(we_low), 32'd6);
    check("st1_read_data_untouched", rdata, 32'h0);
    idle(0);
    check("st1_mem0", 32'(peek(0, 0)), 32'h0000_BEEF);
    check("st1_mem1", 32'(peek(0, 1)), 32'h0000_DEAD);

    // 3: load @1024
    access(0, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, stall, we_low, rdata);
    check("ld1_stall", 32'(stall), 32'd9);
    check("ld1_we_low", 32'(we_low), 32'd0);
    check("ld1_data", rdata, 32'hDEAD_BEEF);
    idle(0);

    // 4: store @1028 with inputs changed mid-access, then back-to-back load
    access(0, 1'b1, 1'b0, 32'd1028, 32'h1234_5678, 1'b1, stall, we_low, rdata);
    check("st2_stall", 32'(stall), 32'd9);
    access(0, 1'b0, 1'b1, 32'd1030, 32'h0, 1'b0, stall, we_low, rdata);
    check("ld2_stall", 32'(stall), 32'd9);
    check("ld2_data", rdata, 32'h1234_5678);
    idle(0);
    check("st2_mem2", 32'(peek(0, 2)), 32'h0000_5678);
    check("st2_mem3", 32'(peek(0, 3)), 32'h0000_1234);

    // 5: reset asserted at cnt=2 of HIGH during a store
    @(negedge clk);
    wr_en[0]      = 1'b1;
    address[0]    = 32'd1024;
    write_data[0] = 32'hCAFE_F00D;
    repeat (7) @(negedge clk);
    #1;
    check("abort_we_low_before_rst", 32'(g_dut[0].we_n), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_we_n", 32'(g_dut[0].we_n), 32'd1);
    check("abort_oe", 32'(g_dut[0].dq_oe), 32'd0);
    check("abort_addr", 32'(g_dut[0].addr), 32'd0);
    check("abort_dq_o", 32'(g_dut[0].dq_o), 32'd0);
    check("abort_read_data", read_data[0], 32'h0);
    wr_en[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(0);
    check("abort_mem0_low_written", 32'(peek(0, 0)), 32'h0000_F00D);
    check("abort_mem1_unchanged", 32'(peek(0, 1)), 32'h0000_DEAD);
    access(0, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, stall, we_low, rdata);
    check("abort_ld_stall", 32'(stall), 32'd9);
    check("abort_ld_data", rdata, 32'hDEAD_F00D);
    idle(0);

    // 6: both requests high -> store
    access(0, 1'b1, 1'b1, 32'd1032, 32'hA5A5_0F0F, 1'b0, stall, we_low, rdata);
    check("both_stall", 32'(stall), 32'd9);
    check("both_we_low", 32'(we_low), 32'd6);
    check("both_read_data_kept", rdata, 32'hDEAD_F00D);
    idle(0);
    check("both_mem4", 32'(peek(0, 4)), 32'h0000_0F0F);
    check("both_mem5", 32'(peek(0, 5)), 32'h0000_A5A5);

    // Address below BASE_ADDR wraps to the top SRAM word
    access(0, 1'b1, 1'b0, 32'd1020, 32'h00C0_FFEE, 1'b0, stall, we_low, rdata);
    idle(0);
    check("wrap_mem_lo", 32'(peek(0, 262142)), 32'h0000_FFEE);
    check("wrap_mem_hi", 32'(peek(0, 262143)), 32'h0000_00C0);

    // WAIT_CYCLES=2 instance: store then load @1024
    access(1, 1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b0, stall, we_low, rdata);
    check("w2_st_stall", 32'(stall), 32'd5);
    check("w2_st_we_low", 32'(we_low), 32'd2);
    idle(1);
    check("w2_mem0", 32'(peek(1, 0)), 32'h0000_BEEF);
    check("w2_mem1", 32'(peek(1, 1)), 32'h0000_DEAD);
    access(1, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, stall, we_low, rdata);
    check("w2_ld_stall", 32'(stall), 32'd5);
    check("w2_ld_data", rdata, 32'hDEAD_BEEF);
    idle(1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
